// File: rtl/matvec_load_ctrl.sv
// matvec_load_ctrl: sequences one matrix-vector job for the MAC.
// Clears the MAC, streams ROWS matrix lines and one vector line from an
// Avalon-MM read master (one read in flight), waits for the MAC and then
// presents the selected row result. Progress is guarded by a timeout.
module matvec_load_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int RES_WIDTH   = 24,
    parameter int TIMEOUT_CYC = 1023,
    localparam int LW    = COLS * DATA_WIDTH,
    localparam int SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      CLOCK_50,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic [ADDR_WIDTH-1:0]     avm_address,
    output logic                      avm_read,
    input  logic [LW-1:0]             avm_readdata,
    input  logic                      avm_readdatavalid,
    input  logic                      avm_waitrequest,
    output logic                      mac_clr,
    output logic                      a_wren,
    output logic                      b_wren,
    output logic [LW-1:0]             line_data,
    input  logic                      mac_done,
    input  logic [ROWS*RES_WIDTH-1:0] mac_result,
    input  logic [SEL_W-1:0]          sel,
    output logic [RES_WIDTH-1:0]      result,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    // Line index runs 0..ROWS (ROWS matrix lines, then the vector line).
    localparam int CNT_W = $clog2(ROWS + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_REQ, S_WAIT_DATA, S_COMPUTE, S_DONE, S_ERROR
    } state_t;

    state_t                    state, state_n;
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [CNT_W-1:0]          count;
    logic [TMO_W-1:0]          tcnt;
    logic [ROWS*RES_WIDTH-1:0] res_q;
    logic                      counting;
    logic                      tmo;

    // Address is base plus line index; the adder wraps naturally.
    assign avm_address = base_q + ADDR_WIDTH'(count);
    assign counting    = (state == S_REQ) || (state == S_WAIT_DATA) || (state == S_COMPUTE);
    // Expires on the cycle the counter would reach TIMEOUT_CYC.
    assign tmo         = counting && (tcnt == TMO_LAST);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and state-decoded outputs; real progress beats the timeout.
    always_comb begin
        state_n  = state;
        mac_clr  = 1'b0;
        avm_read = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_CLEAR;
            S_CLEAR: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
                state_n = S_REQ;
            end
            S_REQ: begin
                busy     = 1'b1;
                avm_read = 1'b1;
                if (!avm_waitrequest) state_n = S_WAIT_DATA;
                else if (tmo)         state_n = S_ERROR;
            end
            S_WAIT_DATA: begin
                busy = 1'b1;
                if (avm_readdatavalid) state_n = (count == LAST_IDX) ? S_COMPUTE : S_REQ;
                else if (tmo)          state_n = S_ERROR;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (mac_done) state_n = S_DONE;
                else if (tmo) state_n = S_ERROR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_CLEAR;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) state_n = S_CLEAR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: run setup, line capture, write strobes, timeout, results.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            count     <= '0;
            tcnt      <= '0;
            res_q     <= '0;
            line_data <= '0;
            a_wren    <= 1'b0;
            b_wren    <= 1'b0;
            result    <= '0;
        end else begin
            a_wren <= 1'b0;
            b_wren <= 1'b0;
            // Every accepted start passes through CLEAR first.
            if (state_n == S_CLEAR) begin
                base_q <= base_addr;
                count  <= '0;
            end
            // Strobes land one cycle after the data, together with line_data.
            if (state == S_WAIT_DATA && avm_readdatavalid) begin
                line_data <= avm_readdata;
                count     <= count + 1'b1;
                a_wren    <= (count < LAST_IDX);
                b_wren    <= (count == LAST_IDX);
            end
            if (state == S_COMPUTE && mac_done)
                res_q <= mac_result;
            if (state_n != state || avm_readdatavalid)
                tcnt <= '0;
            else if (counting)
                tcnt <= tcnt + 1'b1;
            // Result is zero outside DONE, including the cycle a restart leaves it.
            if (state == S_DONE && state_n == S_DONE && int'(sel) < ROWS)
                result <= res_q[int'(sel)*RES_WIDTH +: RES_WIDTH];
            else
                result <= '0;
        end
    end
endmodule

// File: tb/tb_matvec_load_ctrl.sv
// Bench for matvec_load_ctrl: Avalon slave with wait states and latency,
// a behavioural MAC, table-driven runs, random runs against a reference
// matrix-vector product, and hand sequences for the corner cases.
module tb_matvec_load_ctrl;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int RW   = 24;
    localparam int TMO  = 15;
    localparam int LW   = COLS * DW;

    logic              CLOCK_50 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     avm_address;
    logic              avm_read;
    logic [LW-1:0]     avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              avm_waitrequest = 1'b1;
    logic              mac_clr, a_wren, b_wren;
    logic [LW-1:0]     line_data;
    logic              mac_done = 1'b0;
    logic [ROWS*RW-1:0] mac_result = '0;
    logic [2:0]        sel = '0;
    logic [RW-1:0]     result;
    logic              busy, done, err;

    matvec_load_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW),
                       .RES_WIDTH(RW), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .mac_clr(mac_clr), .a_wren(a_wren), .b_wren(b_wren), .line_data(line_data),
        .mac_done(mac_done), .mac_result(mac_result), .sel(sel), .result(result),
        .busy(busy), .done(done), .err(err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Stimulus matrix/vector and slave configuration (written by main only).
    logic [7:0]  A_m [0:ROWS-1][0:COLS-1];
    logic [7:0]  B_v [0:COLS-1];
    logic [31:0] cur_base = '0;
    int          cfg_ws = 0, cfg_lat = 1, drop_idx = -1;
    logic        spur = 1'b0;

    // Line contents are defined relative to the current run's base.
    function automatic logic [LW-1:0] line_for(input logic [31:0] a);
        logic [31:0]   idx;
        logic [LW-1:0] l;
        idx = a - cur_base;
        l = '0;
        for (int c = 0; c < COLS; c++)
            l[c*DW +: DW] = (idx < ROWS) ? A_m[idx[2:0]][c] : B_v[c];
        return l;
    endfunction

    function automatic logic [RW-1:0] ref_row(input int r);
        int s = 0;
        for (int c = 0; c < COLS; c++) s += int'(A_m[r][c]) * int'(B_v[c]);
        return RW'(s);
    endfunction

    // Avalon slave: accepted addresses logged, one read outstanding.
    logic [31:0] addr_q[$];
    int          acc_cyc = 0;
    bit          in_req = 0, have_pend = 0;
    int          ws_left = 0, pend_wait = 0;
    logic [31:0] pend_addr = '0;
    always @(negedge CLOCK_50) begin
        if (!rst_n) begin
            in_req = 0; have_pend = 0;
            avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
        end else begin
            avm_readdatavalid = spur;
            if (spur) avm_readdata = 64'hDEAD_BEEF_0BAD_F00D;
            if (have_pend) begin
                if (pend_wait == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = line_for(pend_addr);
                    have_pend = 0;
                end else pend_wait--;
            end
            if (avm_read) begin
                if (!in_req) begin
                    in_req = 1;
                    ws_left = (cfg_ws < 0) ? int'($urandom_range(0, 3)) : cfg_ws;
                end
                if (ws_left > 0) begin
                    avm_waitrequest = 1'b1; ws_left--;
                end else begin
                    avm_waitrequest = 1'b0; in_req = 0;
                    addr_q.push_back(avm_address);
                    acc_cyc = cyc + 1;
                    if (int'(addr_q.size()) - 1 != drop_idx) begin
                        have_pend = 1; pend_addr = avm_address; pend_wait = cfg_lat - 1;
                    end
                end
            end else begin
                avm_waitrequest = 1'b1; in_req = 0;
            end
        end
    end

    // MAC model: collects written lines, answers after a random delay.
    logic [LW-1:0]      cap_a[$];
    logic [LW-1:0]      cap_b = '0;
    logic [ROWS*RW-1:0] mac_next = '0;
    int a_cnt = 0, b_cnt = 0, clr_cnt = 0, mac_dly = 0;

    function automatic logic [ROWS*RW-1:0] mac_model();
        logic [ROWS*RW-1:0] r;
        logic [LW-1:0]      ln;
        int                 s;
        r = '0;
        for (int i = 0; i < ROWS && i < int'(cap_a.size()); i++) begin
            ln = cap_a[i]; s = 0;
            for (int c = 0; c < COLS; c++) s += int'(ln[c*DW +: DW]) * int'(cap_b[c*DW +: DW]);
            r[i*RW +: RW] = RW'(s);
        end
        return r;
    endfunction

    always @(negedge CLOCK_50) begin
        if (!rst_n) begin
            mac_done = 1'b0; mac_dly = 0;
        end else begin
            if (mac_dly > 0) begin
                mac_dly--;
                if (mac_dly == 0) begin mac_done = 1'b1; mac_result = mac_next; end
            end
            if (mac_clr) begin
                clr_cnt++; cap_a.delete(); a_cnt = 0; b_cnt = 0; mac_done = 1'b0; mac_dly = 0;
            end
            if (a_wren) begin cap_a.push_back(line_data); a_cnt++; end
            if (b_wren) begin
                cap_b = line_data; b_cnt++; mac_next = mac_model();
                mac_dly = $urandom_range(1, 6);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] base);
        @(negedge CLOCK_50); start = 1'b1; base_addr = base;
        @(negedge CLOCK_50); start = 1'b0;
        chk("clear_state", {mac_clr, busy, done, err}, 4'b1100);
        chk("clear_result", result, 0);
        @(negedge CLOCK_50);
        chk("clear_once", mac_clr, 0);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (done || err) break;
        end
    endtask

    task automatic check_run(input logic [31:0] base, input int q0, input int c0);
        int bad;
        chk("run_done", {done, err, busy}, 3'b100);
        chk("n_reads", int'(addr_q.size()) - q0, 9);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (q0 + i >= int'(addr_q.size()) || addr_q[q0+i] !== base + 32'(i)) bad++;
        chk("addr_seq", bad, 0);
        chk("a_wren_cnt", a_cnt, ROWS);
        chk("b_wren_cnt", b_cnt, 1);
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= int'(cap_a.size()) || cap_a[r] !== line_for(cur_base + 32'(r))) bad++;
        chk("a_lines", bad, 0);
        chk("b_line", cap_b, line_for(cur_base + 32'(ROWS)));
        chk("clr_pulses", clr_cnt - c0, 1);
    endtask

    task automatic run_full(input logic [31:0] base, input int ws, input int lat);
        int q0, c0;
        cfg_ws = ws; cfg_lat = lat; cur_base = base;
        q0 = addr_q.size(); c0 = clr_cnt;
        start_run(base);
        wait_end(400);
        check_run(base, q0, c0);
    endtask

    task automatic set_identity();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) A_m[r][c] = (r == c) ? 8'd1 : 8'd0;
        for (int c = 0; c < COLS; c++) B_v[c] = 8'(c + 1);
    endtask

    typedef struct {
        logic [31:0] base;
        int          ws;
        int          lat;
        logic [2:0]  sel;
        logic [23:0] exp_res;
    } vec_t;
    vec_t vecs [4];

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q0, c0, an, bn;
        logic [LW-1:0] ld;
        vecs[0] = '{32'h0000_0000, 2, 3, 3'd5, 24'd6};
        vecs[1] = '{32'hFFFF_FFFC, 0, 1, 3'd0, 24'd1};
        vecs[2] = '{32'h0000_0100, 1, 2, 3'd7, 24'd8};
        vecs[3] = '{32'h7FFF_FFFE, 3, 4, 3'd3, 24'd4};

        set_identity();
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ctrl", {avm_read, mac_clr, a_wren, b_wren, busy, done, err}, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_line", line_data, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        // Table runs: basic run, wrapped restart from DONE, other bases.
        for (int i = 0; i < 4; i++) begin
            run_full(vecs[i].base, vecs[i].ws, vecs[i].lat);
            sel = vecs[i].sel;
            @(negedge CLOCK_50);
            chk("vec_result", result, vecs[i].exp_res);
        end

        // Select sweep in DONE.
        for (int s = 0; s < ROWS; s++) begin
            sel = 3'(s);
            @(negedge CLOCK_50);
            chk("sel_sweep", result, ref_row(s));
        end

        // Stray readdatavalid in DONE must not write anything.
        ld = line_data; an = a_cnt; bn = b_cnt;
        spur = 1'b1; @(negedge CLOCK_50); spur = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("spur_wren", {32'(a_cnt - an), 32'(b_cnt - bn)}, 0);
        chk("spur_line", line_data, ld);
        chk("spur_done", done, 1);

        // Start while busy (WAIT_DATA of line 3) is ignored.
        cfg_ws = 0; cfg_lat = 3; cur_base = 32'h80;
        q0 = addr_q.size(); c0 = clr_cnt;
        start_run(32'h80);
        for (int i = 0; i < 200 && int'(addr_q.size()) - q0 < 4; i++) @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b1; base_addr = 32'h500;
        @(negedge CLOCK_50); start = 1'b0;
        wait_end(400);
        check_run(32'h80, q0, c0);

        // Timeout: line 4 accepted but never answered.
        cfg_ws = 1; cfg_lat = 2; cur_base = 32'h20; drop_idx = int'(addr_q.size()) + 4;
        start_run(32'h20);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_50);
            if (err) break;
        end
        chk("tmo_latency", 64'(cyc - acc_cyc), 15);
        chk("tmo_state", {err, busy, done, avm_read}, 4'b1000);
        chk("tmo_a_cnt", a_cnt, 4);
        repeat (3) @(negedge CLOCK_50);
        chk("tmo_quiet", {32'(a_cnt), 32'(b_cnt)}, {32'd4, 32'd0});
        drop_idx = -1;
        run_full(32'h30, 1, 2);

        // Reset during line 6 REQ.
        cfg_ws = 2; cfg_lat = 2; cur_base = 32'h100;
        q0 = addr_q.size();
        start_run(32'h100);
        for (int i = 0; i < 300 && a_cnt < 6; i++) @(negedge CLOCK_50);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {avm_read, mac_clr, a_wren, b_wren, busy, done, err}, 0);
        chk("mid_rst_addr", avm_address, 0);
        chk("mid_rst_line", line_data, 0);
        repeat (4) @(negedge CLOCK_50);
        chk("mid_rst_reads", int'(addr_q.size()) - q0, 6);
        chk("mid_rst_wren", a_cnt, 6);
        rst_n = 1'b1;
        run_full(32'h200, 2, 3);

        // Random matrices, bases and slave timing against the reference product.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) A_m[r][c] = 8'($urandom_range(0, 255));
            for (int c = 0; c < COLS; c++) B_v[c] = 8'($urandom_range(0, 255));
            run_full($urandom, -1, $urandom_range(1, 4));
            for (int s = 0; s < ROWS; s++) begin
                sel = 3'(s);
                @(negedge CLOCK_50);
                chk("rand_result", result, ref_row(s));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
